handshake_tx_arbiter: RTL and testbench
=======================================

// Module: handshake_tx_arbiter
// PURPOSE
//  Round-robin arbiter sharing one handshake_tclk transmitter among NREQ requesters in the tclk domain.
//  Latches the winner's word, drives data_avail/transmit_data into the transmitter and watches its t_rdy
//  to sequence capture and completion. Acknowledges the winning requester when its word is captured.
// PARAMETERS
//  NREQ         4     number of requesters (2..16)
//  DW           32    data width; matches transmit_data of handshake_tclk
//  TIMEOUT_CYC  1024  watchdog limit in tclk cycles (used only with HSK_ARB_TIMEOUT_EN)
// PORTS
//  tclk           in   1                  transmit-domain clock
//  reset_tclk     in   1                  synchronous, active-high reset
//  req            in   NREQ               per-requester request level
//  req_data       in   NREQ*DW            requester i data at [i*DW +: DW]
//  req_ack        out  NREQ               1-cycle pulse: requester's word captured by transmitter
//  data_avail     out  1                  to handshake_tclk data_avail
//  transmit_data  out  DW                 to handshake_tclk transmit_data
//  t_rdy          in   1                  from handshake_tclk t_rdy
//  busy           out  1                  high whenever state != IDLE
//  owner          out  $clog2(NREQ)       index of current/last winner
//  timeout        out  1                  sticky watchdog flag; tied 0 without HSK_ARB_TIMEOUT_EN
// BEHAVIOUR
//  Reset (sync, active-high on posedge tclk): state=IDLE, data_avail=0, transmit_data=0, req_ack=0,
//   busy=0, owner=0, timeout=0, t_rdy_d1=0, RR pointer=0 (requester 0 highest priority).
//  All outputs registered. t_rdy_d1 is t_rdy delayed 1 tclk; rise = t_rdy&!t_rdy_d1, fall = !t_rdy&t_rdy_d1.
//  FSM states:
//   IDLE : if |req: winner = first set bit scanning ptr, ptr+1, ... (mod NREQ). Next cycle: data_avail=1,
//          transmit_data=req_data[winner], owner=winner, busy=1, -> OFFER. No req: stay, data_avail=0.
//   OFFER: hold data_avail/transmit_data. On rise: data_avail<=0, req_ack[owner]<=1 for exactly 1 cycle,
//          -> BUSY.
//   BUSY : wait for fall (transmitter saw r_ack). On fall: ptr<=owner+1 (wraps NREQ-1 -> 0), -> IDLE.
//  Latency: req asserted in IDLE -> data_avail high 1 cycle later; req_ack 1 cycle after t_rdy rises.
//  Requester rules: hold req and req_data stable until req_ack; dropping req after selection is ignored,
//   latched word is still transferred. Keeping req high after req_ack requests another transfer.
//  Fairness: winner gets lowest priority next round; with all req high, order is 0,1,2,...,NREQ-1,0.
//  Simultaneous fall and new req in BUSY: go IDLE first; arbitrate next cycle (1-cycle bubble, required).
//  rise seen outside OFFER or fall outside BUSY: ignored, no state change.
//  transmit_data keeps the last word after capture; it changes only on a new grant.
//  Reset mid-transfer: arbiter returns to reset values immediately; transmitter resets on its own;
//   no req_ack is issued for the aborted word.
// CONFIGURATION
//  HSK_ARB_TIMEOUT_EN defined: cycle counter cleared on entry to OFFER and BUSY, counts while in either.
//   If it reaches TIMEOUT_CYC: data_avail<=0, timeout<=1 (sticky until reset), ptr<=owner+1, -> IDLE,
//   no req_ack. Further arbitration continues normally.
//  Not defined: no counter logic; OFFER/BUSY wait indefinitely; timeout constant 0.
// TESTING
//  1 Reset: assert reset_tclk 3 cycles with req=4'b1111 -> all outputs 0, no data_avail during reset.
//  2 Single: req=4'b0100, data[2]=32'hDEAD_BEEF, transmitter model raises t_rdy after 1 cycle and drops
//    it 6 cycles later -> data_avail 1 cycle after req, transmit_data=DEADBEEF, owner=2,
//    req_ack=4'b0100 for 1 cycle after t_rdy rises, busy low after t_rdy falls.
//  3 Round robin: req=4'b1111 held, data[i]=i+1 -> grant order 0,1,2,3,0; each ack 1-hot and once per
//    transfer; transmit_data sequence 1,2,3,4,1.
//  4 Wrap/priority: after owner=3, req=4'b1001 -> winner 0; after owner=0, req=4'b1001 -> winner 3.
//  5 Mid-op reset: reset_tclk during BUSY with owner=1 -> next cycle IDLE, ptr=0, req_ack stays 0;
//    with req=4'b0011, next winner is 0.
//  6 HSK_ARB_TIMEOUT_EN, TIMEOUT_CYC=16: t_rdy held 0 in OFFER -> after 16 cycles data_avail=0,
//    timeout=1 sticky, no req_ack, next requester granted. Without macro: data_avail stays 1, timeout=0.

Source files
------------

// File: rtl/handshake_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : handshake_tx_arbiter
//  Purpose  : Round-robin arbiter sharing one handshake_tclk transmitter among
//             NREQ requesters. Optional watchdog enabled by HSK_ARB_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module handshake_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    tclk,
    input  logic                    reset_tclk,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ack,
    output logic                    data_avail,
    output logic [DW-1:0]           transmit_data,
    input  logic                    t_rdy,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    timeout
);

    localparam int c_pw  = $clog2(NREQ);
    localparam int c_pw1 = c_pw + 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_offer = 2'd1;
    localparam logic [1:0] c_st_busy  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic            data_avail_q, data_avail_d;
    logic [DW-1:0]   transmit_data_q, transmit_data_d;
    logic [NREQ-1:0] req_ack_q, req_ack_d;
    logic            busy_q, busy_d;
    logic [c_pw-1:0] owner_q, owner_d;
    logic [c_pw-1:0] ptr_q, ptr_d;
    logic            t_rdy_d1_q, t_rdy_d1_d;

    logic            w_rise, w_fall, w_found;
    logic [c_pw-1:0] w_winner, w_owner_next;
    logic [c_pw:0]   w_sum;
    logic [DW-1:0]   w_word;

    assign w_rise       = t_rdy & ~t_rdy_d1_q;
    assign w_fall       = ~t_rdy & t_rdy_d1_q;
    assign w_owner_next = (owner_q == c_pw'(NREQ - 1)) ? '0 : owner_q + c_pw'(1);
    assign t_rdy_d1_d   = t_rdy;

    // Scan ptr, ptr+1, ... modulo NREQ; first asserted request wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = {1'b0, ptr_q} + c_pw1'(i);
            if (w_sum >= c_pw1'(NREQ)) begin
                w_sum = w_sum - c_pw1'(NREQ);
            end
            if (!w_found && req[w_sum[c_pw-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[c_pw-1:0];
            end
        end
    end

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == c_pw'(i)) begin
                w_word = req_data[i*DW +: DW];
            end
        end
    end

`ifdef HSK_ARB_TIMEOUT_EN
    localparam int c_cw = $clog2(TIMEOUT_CYC + 1);
    logic [c_cw-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
`endif

    always_comb begin
        state_d         = state_q;
        data_avail_d    = data_avail_q;
        transmit_data_d = transmit_data_q;
        owner_d         = owner_q;
        ptr_d           = ptr_q;
        req_ack_d       = '0;
`ifdef HSK_ARB_TIMEOUT_EN
        cnt_d           = cnt_q;
        timeout_d       = timeout_q;
`endif
        case (state_q)
            c_st_idle: begin
                data_avail_d = 1'b0;
                if (w_found) begin
                    state_d         = c_st_offer;
                    data_avail_d    = 1'b1;
                    transmit_data_d = w_word;
                    owner_d         = w_winner;
                end
            end
            c_st_offer: begin
                if (w_rise) begin
                    data_avail_d       = 1'b0;
                    req_ack_d[owner_q] = 1'b1;
                    state_d            = c_st_busy;
                end
            end
            c_st_busy: begin
                if (w_fall) begin
                    ptr_d   = w_owner_next;
                    state_d = c_st_idle;
                end
            end
            default: state_d = c_st_idle;
        endcase
`ifdef HSK_ARB_TIMEOUT_EN
        // Counter restarts on every state entry; expiry abandons the word unacknowledged.
        if ((state_q != c_st_idle) && (state_d == state_q)) begin
            if (cnt_q == c_cw'(TIMEOUT_CYC - 1)) begin
                data_avail_d = 1'b0;
                timeout_d    = 1'b1;
                ptr_d        = w_owner_next;
                state_d      = c_st_idle;
                cnt_d        = '0;
            end else begin
                cnt_d = cnt_q + c_cw'(1);
            end
        end else begin
            cnt_d = '0;
        end
`endif
        busy_d = (state_d != c_st_idle);
    end

    always_ff @(posedge tclk) begin
        if (reset_tclk) begin
            state_q         <= c_st_idle;
            data_avail_q    <= 1'b0;
            transmit_data_q <= '0;
            req_ack_q       <= '0;
            busy_q          <= 1'b0;
            owner_q         <= '0;
            ptr_q           <= '0;
            t_rdy_d1_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            data_avail_q    <= data_avail_d;
            transmit_data_q <= transmit_data_d;
            req_ack_q       <= req_ack_d;
            busy_q          <= busy_d;
            owner_q         <= owner_d;
            ptr_q           <= ptr_d;
            t_rdy_d1_q      <= t_rdy_d1_d;
        end
    end

`ifdef HSK_ARB_TIMEOUT_EN
    always_ff @(posedge tclk) begin
        if (reset_tclk) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    // Constant 0; the comparison keeps the watchdog parameter referenced in this build.
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    assign data_avail    = data_avail_q;
    assign transmit_data = transmit_data_q;
    assign req_ack       = req_ack_q;
    assign busy          = busy_q;
    assign owner         = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_handshake_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_handshake_tx_arbiter
//  Purpose  : Scoreboard bench for handshake_tx_arbiter (NREQ=4, DW=32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_handshake_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int PW   = 2;

    logic              tclk = 1'b0;
    logic              reset_tclk;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ack;
    logic              data_avail;
    logic [DW-1:0]     transmit_data;
    logic              t_rdy;
    logic              busy;
    logic [PW-1:0]     owner;
    logic              timeout;

    typedef struct packed {
        logic [PW-1:0] own;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    handshake_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT_CYC(16)) dut (
        .tclk(tclk), .reset_tclk(reset_tclk), .req(req), .req_data(req_data),
        .req_ack(req_ack), .data_avail(data_avail), .transmit_data(transmit_data),
        .t_rdy(t_rdy), .busy(busy), .owner(owner), .timeout(timeout)
    );

    always #5 tclk = ~tclk;

    task automatic tick();
        @(posedge tclk);
        #1;
    endtask

    task automatic apply_reset();
        reset_tclk = 1'b1;
        req = '0;
        t_rdy = 1'b0;
        repeat (2) tick();
        reset_tclk = 1'b0;
    endtask

    // Transmitter model: t_rdy rises 1 cycle after data_avail, held 6 cycles.
    task automatic serve(input logic [NREQ-1:0] req_after_ack,
                         output logic [PW-1:0] o_own, output logic [DW-1:0] o_dat,
                         output logic [NREQ-1:0] o_ack, output logic [NREQ-1:0] o_ack_after,
                         output bit o_ok);
        o_ok = 1'b0; o_own = '0; o_dat = '0; o_ack = '0; o_ack_after = '0;
        for (int n = 0; n < 50 && !data_avail; n++) tick();
        if (!data_avail) return;
        o_own = owner;
        o_dat = transmit_data;
        tick();
        t_rdy = 1'b1;
        tick();
        o_ack = req_ack;
        req = req_after_ack;
        tick();
        o_ack_after = req_ack;
        repeat (4) tick();
        t_rdy = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (!busy) break;
        end
        o_ok = !busy;
    endtask

    task automatic check_transfer(input string nm, input logic [NREQ-1:0] req_after_ack);
        logic [PW-1:0] own; logic [DW-1:0] dat; logic [NREQ-1:0] ack, ack2; bit ok;
        exp_t e;
        serve(req_after_ack, own, dat, ack, ack2, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: transfer did not complete (data_avail=%b busy=%b)", nm, data_avail, busy);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: unexpected transfer owner=%0d, scoreboard empty", nm, own);
            return;
        end
        e = sb.pop_front();
        if (own !== e.own) begin
            failures++; $display("FAIL %s owner: got %0d expected %0d", nm, own, e.own);
        end
        checks++;
        if (dat !== e.dat) begin
            failures++; $display("FAIL %s data: got %h expected %h", nm, dat, e.dat);
        end
        checks++;
        if (ack !== (NREQ'(1) << e.own)) begin
            failures++; $display("FAIL %s ack: got %b expected %b", nm, ack, NREQ'(1) << e.own);
        end
        checks++;
        if (ack2 !== '0) begin
            failures++; $display("FAIL %s ack width: got %b expected 0000", nm, ack2);
        end
        checks++;
        if (data_avail !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL %s bubble: got avail=%b busy=%b expected 0/0", nm, data_avail, busy);
        end
    endtask

    task automatic test_reset();
        reset_tclk = 1'b1;
        req = 4'b1111;
        t_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({data_avail, busy, timeout, req_ack, owner, transmit_data} !== '0) begin
                failures++;
                $display("FAIL reset cyc%0d: got avail=%b busy=%b to=%b ack=%b own=%0d data=%h expected all 0",
                         c, data_avail, busy, timeout, req_ack, owner, transmit_data);
            end
        end
        reset_tclk = 1'b0;
        req = '0;
        tick();
    endtask

    task automatic test_single();
        apply_reset();
        req_data[2*DW +: DW] = 32'hDEAD_BEEF;
        req = 4'b0100;
        sb.push_back('{own: 2'd2, dat: 32'hDEAD_BEEF});
        tick();
        checks++;
        if (data_avail !== 1'b1 || busy !== 1'b1 || owner !== 2'd2 || transmit_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL single latency: got avail=%b busy=%b own=%0d data=%h expected 1/1/2/deadbeef",
                     data_avail, busy, owner, transmit_data);
        end
        check_transfer("single", 4'b0000);
        checks++;
        if (transmit_data !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL single hold: got %h expected deadbeef", transmit_data);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'(i + 1);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) sb.push_back('{own: PW'(k % NREQ), dat: DW'((k % NREQ) + 1)});
        for (int k = 0; k < 5; k++) check_transfer("rr", (k == 4) ? 4'b0000 : 4'b1111);
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 32'hA0 + DW'(i);
        req = 4'b1000;
        sb.push_back('{own: 2'd3, dat: 32'hA3});
        sb.push_back('{own: 2'd0, dat: 32'hA0});
        sb.push_back('{own: 2'd3, dat: 32'hA3});
        check_transfer("wrap3", 4'b1001);
        check_transfer("wrap0", 4'b1001);
        check_transfer("wrap3b", 4'b0000);
    endtask

    task automatic test_midop_reset();
        logic [NREQ-1:0] ack_seen;
        apply_reset();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 32'h50 + DW'(i);
        req = 4'b0010;
        tick();
        tick();
        t_rdy = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || owner !== 2'd1 || data_avail !== 1'b0) begin
            failures++; $display("FAIL midop busy: got busy=%b own=%0d avail=%b expected 1/1/0", busy, owner, data_avail);
        end
        reset_tclk = 1'b1;
        t_rdy = 1'b0;
        req = 4'b0011;
        tick();
        reset_tclk = 1'b0;
        checks++;
        if (busy !== 1'b0 || owner !== 2'd0 || data_avail !== 1'b0 || req_ack !== '0) begin
            failures++;
            $display("FAIL midop idle: got busy=%b own=%0d avail=%b ack=%b expected 0/0/0/0000",
                     busy, owner, data_avail, req_ack);
        end
        sb.push_back('{own: 2'd0, dat: 32'h50});
        ack_seen = '0;
        tick();
        ack_seen |= req_ack;
        checks++;
        if (data_avail !== 1'b1 || owner !== 2'd0) begin
            failures++; $display("FAIL midop regrant: got avail=%b own=%0d expected 1/0", data_avail, owner);
        end
        checks++;
        if (ack_seen !== '0) begin
            failures++; $display("FAIL midop ack: got %b expected 0000", ack_seen);
        end
        check_transfer("midop", 4'b0000);
    endtask

    task automatic test_timeout();
        logic [NREQ-1:0] ack_or;
        apply_reset();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 32'h70 + DW'(i);
        req = 4'b0001;
        tick();
        req = 4'b0011;
        ack_or = '0;
        repeat (15) begin
            tick();
            ack_or |= req_ack;
        end
        checks++;
        if (data_avail !== 1'b1 || timeout !== 1'b0) begin
            failures++; $display("FAIL timeout early: got avail=%b to=%b expected 1/0", data_avail, timeout);
        end
        tick();
        ack_or |= req_ack;
`ifdef HSK_ARB_TIMEOUT_EN
        checks++;
        if (data_avail !== 1'b0 || timeout !== 1'b1 || busy !== 1'b0 || ack_or !== '0) begin
            failures++;
            $display("FAIL timeout fire: got avail=%b to=%b busy=%b ack=%b expected 0/1/0/0000",
                     data_avail, timeout, busy, ack_or);
        end
        sb.push_back('{own: 2'd1, dat: 32'h71});
        tick();
        checks++;
        if (data_avail !== 1'b1 || owner !== 2'd1 || timeout !== 1'b1) begin
            failures++; $display("FAIL timeout next: got avail=%b own=%0d to=%b expected 1/1/1", data_avail, owner, timeout);
        end
        check_transfer("timeout_next", 4'b0000);
        checks++;
        if (timeout !== 1'b1) begin
            failures++; $display("FAIL timeout sticky: got %b expected 1", timeout);
        end
`else
        repeat (10) begin
            tick();
            ack_or |= req_ack;
        end
        checks++;
        if (data_avail !== 1'b1 || timeout !== 1'b0 || owner !== 2'd0 || ack_or !== '0) begin
            failures++;
            $display("FAIL no-timeout wait: got avail=%b to=%b own=%0d ack=%b expected 1/0/0/0000",
                     data_avail, timeout, owner, ack_or);
        end
        sb.push_back('{own: 2'd0, dat: 32'h70});
        check_transfer("no_timeout", 4'b0000);
`endif
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL scoreboard drain: got %0d left expected 0", sb.size());
        end
    endtask

    initial begin
        reset_tclk = 1'b1;
        req = '0;
        req_data = '0;
        t_rdy = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_midop_reset();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
